// File: rtl/opfetch_if.sv
// Operand-fetch bundle: upstream request, register-file read/snoop ports
// and the downstream operand handshake.
`timescale 1ns/1ps
interface opfetch_if #(
  parameter int TAGW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_ra;
  logic [3:0]      in_rb;
  logic [TAGW-1:0] in_tag;
  logic [3:0]      raddr0_;
  logic [3:0]      raddr1_;
  logic [15:0]     rdata0;
  logic [15:0]     rdata1;
  logic            wen;
  logic [3:0]      waddr;
  logic [15:0]     wdata;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_a;
  logic [15:0]     out_b;
  logic [TAGW-1:0] out_tag;

  // Environment side: issues requests, owns the register file, consumes operands.
  modport master (
    output in_valid, in_ra, in_rb, in_tag, rdata0, rdata1, wen, waddr, wdata, out_ready,
    input  in_ready, raddr0_, raddr1_, out_valid, out_a, out_b, out_tag
  );

  // Operand-fetch block side.
  modport slave (
    input  in_valid, in_ra, in_rb, in_tag, rdata0, rdata1, wen, waddr, wdata, out_ready,
    output in_ready, raddr0_, raddr1_, out_valid, out_a, out_b, out_tag
  );
endinterface

// File: rtl/opfetch.sv
// Two-stage operand fetch: S1 holds indices/tag while the register file
// reads, S2 is the output register holding the captured operands. A write
// landing on the capture edge is forwarded from the snooped write port.
`timescale 1ns/1ps
module opfetch #(
  parameter int TAGW   = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  opfetch_if.slave bus
);
  // S1 state
  logic            r_s1_valid;
  logic [3:0]      r_s1_ra;
  logic [3:0]      r_s1_rb;
  logic [TAGW-1:0] r_s1_tag;
  // S2 (output) state
  logic            r_out_valid;
  logic [15:0]     r_out_a;
  logic [15:0]     r_out_b;
  logic [TAGW-1:0] r_out_tag;

  logic        w_s2_free;
  logic        w_s1_adv;
  logic        w_in_ready;
  logic        w_accept;
  logic [15:0] w_op_a;
  logic [15:0] w_op_b;
  logic [3:0]  w_raddr0;
  logic [3:0]  w_raddr1;

  assign w_s2_free  = !r_out_valid | bus.out_ready;
  assign w_s1_adv   = r_s1_valid & w_s2_free;
  assign w_in_ready = !r_s1_valid | w_s1_adv;
  assign w_accept   = bus.in_valid & w_in_ready;

  // Read-address steering: new indices on accept (and throughout reset),
  // otherwise keep re-presenting the S1 indices so rdata tracks S1.
  always_comb begin
    w_raddr0 = r_s1_ra;
    w_raddr1 = r_s1_rb;
    if (rst || w_accept) begin
      w_raddr0 = bus.in_ra;
      w_raddr1 = bus.in_rb;
    end else begin
      w_raddr0 = r_s1_ra;
      w_raddr1 = r_s1_rb;
    end
  end

  // Operand selection at capture: forward the snooped write when it targets
  // the S1 index on this very edge, independently for A and B.
  always_comb begin
    w_op_a = bus.rdata0;
    w_op_b = bus.rdata1;
    if (BYPASS && bus.wen && (bus.waddr == r_s1_ra)) begin
      w_op_a = bus.wdata;
    end else begin
      w_op_a = bus.rdata0;
    end
    if (BYPASS && bus.wen && (bus.waddr == r_s1_rb)) begin
      w_op_b = bus.wdata;
    end else begin
      w_op_b = bus.rdata1;
    end
  end

  // S1 register: load on accept, empty when it advances without a refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_ra    <= 4'd0;
      r_s1_rb    <= 4'd0;
      r_s1_tag   <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_ra    <= bus.in_ra;
      r_s1_rb    <= bus.in_rb;
      r_s1_tag   <= bus.in_tag;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2 output register: capture on S1 advance, drop valid once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_a     <= 16'd0;
      r_out_b     <= 16'd0;
      r_out_tag   <= '0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_out_a     <= w_op_a;
      r_out_b     <= w_op_b;
      r_out_tag   <= r_s1_tag;
    end else if (w_s2_free) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.raddr0_   = w_raddr0;
  assign bus.raddr1_   = w_raddr1;
  assign bus.out_valid = r_out_valid;
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.out_tag   = r_out_tag;
endmodule
